// File: rtl/sync_ctrl_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ctrl_param_if
//  Description : Code-group bus between the 10b/8b decoder, the receive
//                synchronisation block and its consumers.
//                slave  : the sync block (samples decoder side, drives results)
//                master : the environment (drives decoder side, reads results)
//  Signals     : i_Cke, i_CtrlLoopBack, i8_RxCodeGroupIn, i_RxCodeInvalid,
//                i_RxCodeCtrl, i_SignalDetect, i_LossCntClr        (to block)
//                o8_RxCodeGroupOut, o_RxCodeInvalid, o_RxCodeCtrl, o_RxEven,
//                o_SyncStatus, o_IsComma, o2_BadLevel, o_LossCnt,
//                o_BitSlip                                        (from block)
//  Revision    : 1.0  initial release
// ============================================================================
interface sync_ctrl_param_if #(
    parameter int MAX_BAD = 3,
    parameter int CNT_W   = 8
);
    localparam int c_BL_W = $clog2(MAX_BAD + 1);

    logic              i_Cke;
    logic              i_CtrlLoopBack;
    logic [7:0]        i8_RxCodeGroupIn;
    logic              i_RxCodeInvalid;
    logic              i_RxCodeCtrl;
    logic              i_SignalDetect;
    logic              i_LossCntClr;
    logic [7:0]        o8_RxCodeGroupOut;
    logic              o_RxCodeInvalid;
    logic              o_RxCodeCtrl;
    logic              o_RxEven;
    logic              o_SyncStatus;
    logic              o_IsComma;
    logic [c_BL_W-1:0] o2_BadLevel;
    logic [CNT_W-1:0]  o_LossCnt;
    logic              o_BitSlip;

    modport master (
        output i_Cke, i_CtrlLoopBack, i8_RxCodeGroupIn, i_RxCodeInvalid,
               i_RxCodeCtrl, i_SignalDetect, i_LossCntClr,
        input  o8_RxCodeGroupOut, o_RxCodeInvalid, o_RxCodeCtrl, o_RxEven,
               o_SyncStatus, o_IsComma, o2_BadLevel, o_LossCnt, o_BitSlip
    );

    modport slave (
        input  i_Cke, i_CtrlLoopBack, i8_RxCodeGroupIn, i_RxCodeInvalid,
               i_RxCodeCtrl, i_SignalDetect, i_LossCntClr,
        output o8_RxCodeGroupOut, o_RxCodeInvalid, o_RxCodeCtrl, o_RxEven,
               o_SyncStatus, o_IsComma, o2_BadLevel, o_LossCnt, o_BitSlip
    );
endinterface
`default_nettype wire

// File: rtl/sync_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ctrl_param
//  Description : 1000BASE-X/SGMII receive synchronisation. Qualifies decoded
//                code-groups, tracks even/odd alignment, runs the acquire /
//                lose-sync state machine with configurable thresholds, counts
//                sync-lost events and (optionally) requests SerDes bit slips.
//  Ports       : i_Clk     clock, rising edge
//                i_ARst_L  asynchronous active-low reset
//                bus       sync_ctrl_param_if.slave (code-group in, registered
//                          code-group / status / counters out)
//  Options     : SYNC_BITSLIP_EN  builds the bit-slip timeout counter; when
//                undefined o_BitSlip is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ctrl_param #(
    parameter int ACQ_COMMAS   = 3,
    parameter int GOOD_CGS     = 4,
    parameter int MAX_BAD      = 3,
    parameter int SLIP_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  wire logic        i_Clk,
    input  wire logic        i_ARst_L,
    sync_ctrl_param_if.slave bus
);
    localparam int c_BL_W   = $clog2(MAX_BAD + 1);
    localparam int c_ACQ_W  = $clog2(ACQ_COMMAS + 1);
    localparam int c_GOOD_W = $clog2(GOOD_CGS + 1);

    localparam logic [c_ACQ_W-1:0]  c_ACQ_LAST  = c_ACQ_W'(ACQ_COMMAS);
    localparam logic [c_GOOD_W-1:0] c_GOOD_WRAP = c_GOOD_W'(GOOD_CGS - 1);
    localparam logic [c_BL_W-1:0]   c_BAD_LAST  = c_BL_W'(MAX_BAD);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

    if (ACQ_COMMAS < 1 || GOOD_CGS < 1 || MAX_BAD < 1 || SLIP_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_params
        $error("sync_ctrl_param: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_LOSS      = 2'd0,
        ST_COMMA_DET = 2'd1,
        ST_ACQ_SYNC  = 2'd2,
        ST_SYNC_ACQ  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_ACQ_W-1:0]  r_acq_cnt, w_acq_nxt;
    logic [c_GOOD_W-1:0] r_good_cnt, w_good_nxt;
    logic [c_BL_W-1:0]   r_level, w_level_nxt;
    logic                r_even, w_even_nxt;
    logic                w_loss_evt;
    logic [CNT_W-1:0]    r_loss_cnt;
    logic [7:0]          r_cg;
    logic                r_inv, r_ctrl, r_comma;

    logic w_comma, w_data, w_cgbad, w_sigok;

    assign w_comma = ~bus.i_RxCodeInvalid & bus.i_RxCodeCtrl &
                     ((bus.i8_RxCodeGroupIn == 8'hBC) ||
                      (bus.i8_RxCodeGroupIn == 8'h3C) ||
                      (bus.i8_RxCodeGroupIn == 8'hFC));
    assign w_data  = ~bus.i_RxCodeInvalid & ~bus.i_RxCodeCtrl;
    // A comma landing on the odd slot means alignment has shifted.
    assign w_cgbad = bus.i_RxCodeInvalid | (w_comma & r_even);
    assign w_sigok = bus.i_SignalDetect | bus.i_CtrlLoopBack;

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r_state    <= ST_LOSS;
            r_acq_cnt  <= '0;
            r_good_cnt <= '0;
            r_level    <= '0;
            r_even     <= 1'b0;
            r_loss_cnt <= '0;
            r_cg       <= '0;
            r_inv      <= 1'b0;
            r_ctrl     <= 1'b0;
            r_comma    <= 1'b0;
        end else if (bus.i_Cke) begin
            r_state    <= w_state_nxt;
            r_acq_cnt  <= w_acq_nxt;
            r_good_cnt <= w_good_nxt;
            r_level    <= w_level_nxt;
            r_even     <= w_even_nxt;
            r_cg       <= bus.i8_RxCodeGroupIn;
            r_inv      <= bus.i_RxCodeInvalid;
            r_ctrl     <= bus.i_RxCodeCtrl;
            r_comma    <= w_comma;
            // Clear beats a coincident loss so software never misses a reset.
            if (bus.i_LossCntClr) begin
                r_loss_cnt <= '0;
            end else if (w_loss_evt && (r_loss_cnt != c_CNT_MAX)) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq_cnt;
        w_good_nxt  = r_good_cnt;
        w_level_nxt = r_level;
        w_even_nxt  = ~r_even;
        w_loss_evt  = 1'b0;

        case (r_state)
            ST_LOSS: begin
                if (w_comma) begin
                    w_state_nxt = ST_COMMA_DET;
                    w_acq_nxt   = c_ACQ_W'(1);
                    w_even_nxt  = 1'b1;
                end
            end
            ST_COMMA_DET: begin
                if (!w_data) begin
                    w_state_nxt = ST_LOSS;
                end else if (r_acq_cnt == c_ACQ_LAST) begin
                    w_state_nxt = ST_SYNC_ACQ;
                end else begin
                    w_state_nxt = ST_ACQ_SYNC;
                end
            end
            ST_ACQ_SYNC: begin
                if (w_cgbad) begin
                    w_state_nxt = ST_LOSS;
                end else if (w_comma && !r_even) begin
                    w_state_nxt = ST_COMMA_DET;
                    w_acq_nxt   = r_acq_cnt + 1'b1;
                    w_even_nxt  = 1'b1;
                end
            end
            ST_SYNC_ACQ: begin
                if (w_cgbad) begin
                    if (r_level == c_BAD_LAST) begin
                        w_state_nxt = ST_LOSS;
                        w_loss_evt  = 1'b1;
                    end else begin
                        w_level_nxt = r_level + 1'b1;
                        w_good_nxt  = '0;
                    end
                end else if (r_level != '0) begin
                    if (r_good_cnt == c_GOOD_WRAP) begin
                        w_level_nxt = r_level - 1'b1;
                        w_good_nxt  = '0;
                    end else begin
                        w_good_nxt  = r_good_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_LOSS;
        endcase

        // Losing the signal overrides every transition, including the
        // even-slot realignment on a comma.
        if (!w_sigok) begin
            w_state_nxt = ST_LOSS;
            w_even_nxt  = ~r_even;
            w_loss_evt  = (r_state == ST_SYNC_ACQ);
        end

        // Bad level and good run only have meaning while in sync; entering
        // SYNC_ACQ therefore always starts from level 0.
        if (w_state_nxt != ST_SYNC_ACQ) begin
            w_level_nxt = '0;
            w_good_nxt  = '0;
        end
    end

`ifdef SYNC_BITSLIP_EN
    localparam int                 c_SLIP_W    = $clog2(SLIP_TIMEOUT);
    localparam logic [c_SLIP_W-1:0] c_SLIP_LAST = c_SLIP_W'(SLIP_TIMEOUT - 1);

    logic [c_SLIP_W-1:0] r_slip_cnt;
    logic                w_slip_hit;

    assign w_slip_hit = (r_state == ST_LOSS) && (r_slip_cnt == c_SLIP_LAST);

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            r_slip_cnt <= '0;
        end else if (bus.i_Cke) begin
            if ((r_state != ST_LOSS) || w_comma || w_slip_hit) begin
                r_slip_cnt <= '0;
            end else begin
                r_slip_cnt <= r_slip_cnt + 1'b1;
            end
        end
    end

    assign bus.o_BitSlip = bus.i_Cke & w_slip_hit;
`else
    assign bus.o_BitSlip = 1'b0;
`endif

    assign bus.o8_RxCodeGroupOut = r_cg;
    assign bus.o_RxCodeInvalid   = r_inv;
    assign bus.o_RxCodeCtrl      = r_ctrl;
    assign bus.o_IsComma         = r_comma;
    assign bus.o_RxEven          = r_even;
    assign bus.o_SyncStatus      = (r_state == ST_SYNC_ACQ);
    assign bus.o2_BadLevel       = r_level;
    assign bus.o_LossCnt         = r_loss_cnt;

endmodule
`default_nettype wire

// File: doc/sync_ctrl_param.md
# sync_ctrl_param

Parametrised 1000BASE-X/SGMII receive synchronisation block: qualifies 8b/10b-decoded code-groups, tracks even/odd alignment, and runs the acquire/lose-sync state machine with configurable thresholds. It sits between the 10b/8b decoder and the receive/auto-negotiation state machines, replacing the fixed-threshold sync controller. It adds a loss-of-sync event counter and an optional bit-slip request generator for the SerDes word aligner.

## Interface
- ACQ_COMMAS, 3: comma+data pairs required to acquire sync (>=1)
- GOOD_CGS, 4: consecutive good code-groups that clear one bad level (>=1)
- MAX_BAD, 3: bad levels tolerated; next bad code-group drops sync (>=1)
- SLIP_TIMEOUT, 64: Cke cycles in LOSS without comma before bit-slip pulse (>=2)
- CNT_W, 8: width of loss-of-sync counter
- i_Clk in 1: clock, rising edge
- i_ARst_L in 1: reset, asynchronous, active-low
- i_Cke in 1: clock enable; all state holds when low
- i_CtrlLoopBack in 1: loopback; ignore i_SignalDetect
- i8_RxCodeGroupIn in 8: decoded code-group
- i_RxCodeInvalid in 1: code-group invalid / disparity error
- i_RxCodeCtrl in 1: code-group is K-character
- i_SignalDetect in 1: PMD signal detect
- i_LossCntClr in 1: synchronous clear of o_LossCnt
- o8_RxCodeGroupOut out 8: registered code-group
- o_RxCodeInvalid out 1: registered invalid flag
- o_RxCodeCtrl out 1: registered ctrl flag
- o_RxEven out 1: even/odd position flag
- o_SyncStatus out 1: sync acquired
- o_IsComma out 1: registered comma flag
- o2_BadLevel out 2..: current bad level, width $clog2(MAX_BAD+1)
- o_LossCnt out CNT_W: saturating count of sync-lost events
- o_BitSlip out 1: one-cycle bit-slip request

## Operation
- comma = ~invalid & ctrl & byte in {BC,3C,FC}; data = ~invalid & ~ctrl; cgbad = invalid | (comma & o_RxEven==1).
- sigok = i_SignalDetect | i_CtrlLoopBack. sigok low (level) forces LOSS, overriding all transitions.
- States: LOSS, COMMA_DET, ACQ_SYNC, SYNC_ACQ; internal acq_cnt, good_cnt, bad level.
- LOSS: comma -> COMMA_DET, acq_cnt=1, RxEven<=1. Otherwise stay.
- COMMA_DET: data -> SYNC_ACQ (level 0, good_cnt 0) if acq_cnt==ACQ_COMMAS, else ACQ_SYNC; non-data -> LOSS.
- ACQ_SYNC: cgbad -> LOSS; comma & RxEven==0 -> COMMA_DET, acq_cnt+1, RxEven<=1; else stay.
- SYNC_ACQ: cgbad with level==MAX_BAD -> LOSS, o_LossCnt+1; cgbad otherwise -> level+1, good_cnt=0. Good code-group with level>0: good_cnt+1; when good_cnt reaches GOOD_CGS -> level-1, good_cnt=0. Level 0 ignores good code-groups.
- RxEven toggles every Cke cycle except where forced to 1 above.
- o_LossCnt saturates at all-ones; i_LossCntClr wins over a simultaneous increment. Counts only SYNC_ACQ->LOSS exits, including sigok-forced ones.
- Code-group, invalid, ctrl, comma outputs are one-stage registers, updated only with Cke.

## Timing
- Reset: state LOSS, all outputs 0, all counters 0.
- o_SyncStatus, o2_BadLevel: decode of registered state; high the cycle after the ACQ_COMMAS-th qualifying data code-group is sampled.
- Sync loss: o_SyncStatus low the cycle after the (MAX_BAD+1)-th unrecovered cgbad, or after sigok low.
- o_LossCnt updates the same edge as the state enters LOSS.
- Data path latency: exactly 1 Cke cycle.
- i_Cke low: no state, counter or output register changes; o_BitSlip forced 0.
- Reset mid-operation: immediate return to reset values, no partial counts retained.

## Configuration
- SYNC_BITSLIP_EN defined: slip counter runs in LOSS per Cke cycle, cleared by comma or leaving LOSS. At SLIP_TIMEOUT-1 it pulses o_BitSlip for one Cke cycle and restarts. No pulse outside LOSS.
- Undefined: slip counter not built; o_BitSlip tied 0.

## Test plan
- Reset, then K28.5/D16.2 pairs repeated with sigok=1 (defaults) -> o_SyncStatus=1 one cycle after the third D16.2; o_RxEven alternates, 1 on K28.5 cycles.
- Sync held, one invalid code-group then 4 good -> o2_BadLevel 1 then back to 0; o_SyncStatus stays 1.
- Sync held, 4 consecutive invalid code-groups -> o_SyncStatus=0 after the 4th; o_LossCnt=1.
- Sync held, i_SignalDetect=0 with i_CtrlLoopBack=0 -> LOSS next cycle. Repeat with i_CtrlLoopBack=1 -> sync kept.
- CNT_W=2, force 5 losses, then assert i_LossCntClr coincident with a loss -> count stops at 3, then reads 0.
- SYNC_BITSLIP_EN defined, only D0.0 for 200 cycles -> o_BitSlip pulses at cycles 64, 128, 192; none with macro undefined.
